// File: rtl/vram_pkg.sv
// Shared VRAM definitions used by the frame-buffer writer and the display reader.
package vram_pkg;

  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 36;
  localparam int PIXEL_W     = 30;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_WRITING  = 2'd1,
    ST_DONE     = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [PIXEL_W-1:0]     data;
    logic                   last;
  } wr_entry_t;

  // ZBT words are wider than a pixel; the spare top bits are written as zero.
  function automatic logic [VRAM_DATA_W-1:0] pack_pixel(input logic [PIXEL_W-1:0] pix);
    return {{(VRAM_DATA_W-PIXEL_W){1'b0}}, pix};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO of pending VRAM writes; full/empty are registered so
// the pixel-side ready never depends combinationally on the arbiter grant.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wr_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/vram_write_img.sv
// Frame-buffer writer: turns a pixel stream into linear VRAM word writes,
// buffering pixels until the arbiter grants a write slot.
module vram_write_img
  import vram_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_W-1:0]     pix_data,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  input  logic                   wr_slot,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic [VRAM_DATA_W-1:0] vram_write_data,
  output logic                   vram_we,
  output logic                   frame_done
);

  if (WIDTH * HEIGHT + BASE_ADDR > (1 << VRAM_ADDR_W)) begin : g_size_check
    $error("vram_write_img: frame does not fit in the VRAM address space");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("vram_write_img: FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam logic [VRAM_ADDR_W-1:0] X_LAST = VRAM_ADDR_W'(WIDTH - 1);
  localparam logic [VRAM_ADDR_W-1:0] Y_LAST = VRAM_ADDR_W'(HEIGHT - 1);
  localparam logic [VRAM_ADDR_W-1:0] LINE   = VRAM_ADDR_W'(WIDTH);
  localparam logic [VRAM_ADDR_W-1:0] BASE   = VRAM_ADDR_W'(BASE_ADDR);

  wr_state_t              state;
  logic [VRAM_ADDR_W-1:0] x;
  logic [VRAM_ADDR_W-1:0] y;
  logic [VRAM_ADDR_W-1:0] row_base;

  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   last;
  logic [VRAM_ADDR_W-1:0] cur_x;
  logic [VRAM_ADDR_W-1:0] cur_y;
  logic [VRAM_ADDR_W-1:0] cur_row;
  wr_entry_t              push_entry;
  wr_entry_t              head;

  assign pix_ready = !full && reset;
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && (pix_sof || state == ST_WRITING);
  assign pop       = wr_slot && !empty;

  // A sof pixel is always (0,0), whatever position the counters hold.
  assign cur_x   = pix_sof ? '0 : x;
  assign cur_y   = pix_sof ? '0 : y;
  assign cur_row = pix_sof ? '0 : row_base;
  assign last    = (cur_x == X_LAST) && (cur_y == Y_LAST);

  assign push_entry = '{addr: BASE + cur_row + cur_x, data: pix_data, last: last};

  // Position tracking and frame state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_WAIT_SOF;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
    end else if (push) begin
      if (cur_x == X_LAST) begin
        x        <= '0;
        y        <= cur_y + 1'b1;
        row_base <= cur_row + LINE;
      end else begin
        x        <= cur_x + 1'b1;
        y        <= cur_y;
        row_base <= cur_row;
      end
      state <= last ? ST_DONE : ST_WRITING;
    end
  end

  vram_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Drain stage: one registered VRAM write per granted slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      vram_we         <= 1'b0;
      frame_done      <= 1'b0;
      vram_addr       <= '0;
      vram_write_data <= '0;
    end else begin
      vram_we    <= pop;
      frame_done <= pop && head.last;
      if (pop) begin
        vram_addr       <= head.addr;
        vram_write_data <= pack_pixel(head.data);
      end
    end
  end

endmodule

// File: tb/tb_vram_write_img.sv
// Randomized bench for vram_write_img against a pixel-index frame model.
module tb_vram_write_img;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int BASE  = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic        pix_ready;
  logic        wr_slot = 1'b0;
  logic [18:0] vram_addr;
  logic [35:0] vram_write_data;
  logic        vram_we;
  logic        frame_done;

  always #5 clk = ~clk;

  vram_write_img #(
    .WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_sof         (pix_sof),
    .pix_ready       (pix_ready),
    .wr_slot         (wr_slot),
    .vram_addr       (vram_addr),
    .vram_write_data (vram_write_data),
    .vram_we         (vram_we),
    .frame_done      (frame_done)
  );

  typedef struct {
    logic [18:0] addr;
    logic [29:0] data;
    bit          last;
  } ent_t;

  ent_t        q[$];
  bit          in_frame = 0;
  int unsigned pix_n = 0;
  bit          exp_known = 0;
  logic        exp_we = 0;
  logic        exp_done = 0;
  logic [18:0] exp_addr = '0;
  logic [35:0] exp_data = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_done = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check last edge's outputs, drive inputs, predict the next edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [29:0] d, input bit slot);
    bit   acc;
    bit   exp_ready;
    ent_t e;
    @(negedge clk);
    if (exp_known) begin
      chk("vram_we", vram_we, exp_we);
      chk("frame_done", frame_done, exp_done);
      chk("vram_addr", vram_addr, exp_addr);
      chk("vram_write_data", vram_write_data, exp_data);
      if (vram_we === 1'b1) n_writes++;
      if (frame_done === 1'b1) n_done++;
    end
    reset = r; pix_valid = v; pix_sof = s; pix_data = d; wr_slot = slot;
    #1;
    exp_ready = r && (q.size() < DEPTH);
    chk("pix_ready", pix_ready, exp_ready);
    if (!r) begin
      q.delete();
      in_frame = 0; pix_n = 0;
      exp_we = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
      exp_known = 1;
    end else begin
      acc = v && exp_ready;
      if (slot && q.size() > 0) begin
        e = q.pop_front();
        exp_we = 1; exp_done = e.last; exp_addr = e.addr; exp_data = {6'd0, e.data};
      end else begin
        exp_we = 0; exp_done = 0;
      end
      if (acc && s) begin
        in_frame = 1; pix_n = 0;
      end
      if (acc && in_frame) begin
        e.addr = 19'(BASE + pix_n);
        e.data = d;
        e.last = (pix_n == W * H - 1);
        q.push_back(e);
        pix_n++;
        if (e.last) in_frame = 0;
      end
    end
    @(posedge clk);
  endtask

  function automatic logic [29:0] rpix();
    return 30'($urandom);
  endfunction

  initial begin
    int w0, d0;
    repeat (3) step(0, 0, 0, '0, 0);

    // single pixel: write appears two cycles after acceptance
    step(1, 1, 1, 30'h3FF00000, 1);
    step(1, 0, 0, '0, 1);
    #2;
    chk("first_we", vram_we, 1);
    chk("first_addr", vram_addr, BASE);
    chk("first_data", vram_write_data, 36'h003FF00000);
    repeat (2) step(1, 0, 0, '0, 1);

    // complete frame at full rate
    w0 = n_writes; d0 = n_done;
    step(1, 1, 1, rpix(), 1);
    for (int i = 1; i < W * H; i++) step(1, 1, 0, rpix(), 1);
    repeat (4) step(1, 0, 0, '0, 1);
    chk("frame_writes", n_writes - w0, W * H + 1 - 1);
    chk("frame_done_count", n_done - d0, 1);

    // pixels without sof after the frame are dropped
    w0 = n_writes;
    for (int i = 0; i < 6; i++) step(1, 1, 0, rpix(), 1);
    repeat (2) step(1, 0, 0, '0, 1);
    chk("dropped_writes", n_writes - w0, 0);

    // backpressure: five offered with no grant, then drain
    step(1, 1, 1, rpix(), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, rpix(), 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, '0, 1);

    // restart mid-frame at line 2
    step(1, 1, 1, rpix(), 1);
    for (int i = 0; i < 2 * W + 3; i++) step(1, 1, 0, rpix(), 1);
    d0 = n_done;
    step(1, 1, 1, rpix(), 1);
    repeat (4) step(1, 0, 0, '0, 1);
    chk("restart_no_done", n_done - d0, 0);

    // reset with buffered pixels discards them
    step(1, 1, 0, rpix(), 0);
    step(1, 1, 0, rpix(), 0);
    step(1, 1, 0, rpix(), 0);
    step(0, 1, 0, rpix(), 1);
    w0 = n_writes;
    repeat (5) step(1, 0, 0, '0, 1);
    chk("post_reset_writes", n_writes - w0, 0);

    // randomized traffic with occasional sof and reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 2),
           rpix(),
           ($urandom_range(0, 3) != 0));
    end
    repeat (6) step(1, 0, 0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
